// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
// Sequences the command stream for one convolution layer:
//   BIAS -> LRELU -> WEIGHT -> { {FEAT, CONV} x BATCH_NUM, RX } x ROW_GRP_NUM -> DONE
// Each command phase has an ISSUE sub-state, where the command is offered until the
// accelerator accepts it, and a WAIT sub-state, where the accelerator's task_finish
// pulse is awaited.
// Ports:
//   sclk, s_rst_n          clock, asynchronous active-low reset
//   start, abort           layer start pulse, synchronous abort (highest priority)
//   cmd_valid/cmd_ready    command handshake
//   cmd_type               1=BIAS 2=LRELU 3=WEIGHT 4=FEAT 5=CONV 6=RX, 0 when idle
//   cmd_batch, cmd_row     batch / row-group index of the current command
//   cmd_first, cmd_last    first / last row-group flags (FEAT/CONV/RX only)
//   task_finish            completion pulse from the accelerator
//   src_sel                MM2S stream mux select (loader phases only)
//   busy, done             layer in progress, one-cycle completion pulse
// All outputs are registered and are decoded from the next-state values, so they
// change on the same edge as the state.
module conv_layer_scheduler #(
  parameter int BATCH_NUM   = 2,
  parameter int ROW_GRP_NUM = 13,
  parameter int CNT_W       = 8
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_type,
  output logic [CNT_W-1:0] cmd_batch,
  output logic [CNT_W-1:0] cmd_row,
  output logic             cmd_first,
  output logic             cmd_last,
  input  logic             task_finish,
  output logic [2:0]       src_sel,
  output logic             busy,
  output logic             done
);

  // Phase encoding equals the command type code so cmd_type/src_sel decode directly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BIAS   = 3'd1,
    ST_LRELU  = 3'd2,
    ST_WEIGHT = 3'd3,
    ST_FEAT   = 3'd4,
    ST_CONV   = 3'd5,
    ST_RX     = 3'd6,
    ST_DONE   = 3'd7
  } phase_e;

  localparam logic [CNT_W-1:0] BATCH_LAST = CNT_W'(BATCH_NUM - 1);
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_GRP_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  phase_e           phase_q, phase_d;
  logic             wait_q, wait_d;
  logic [CNT_W-1:0] batch_q, batch_d;
  logic [CNT_W-1:0] row_q, row_d;

  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_type_q, cmd_type_d;
  logic [CNT_W-1:0] cmd_batch_q, cmd_batch_d;
  logic [CNT_W-1:0] cmd_row_q, cmd_row_d;
  logic             cmd_first_q, cmd_first_d;
  logic             cmd_last_q, cmd_last_d;
  logic [2:0]       src_sel_q, src_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic: phase, sub-state and row/batch counters.
  always_comb begin
    phase_d = phase_q;
    wait_d  = wait_q;
    batch_d = batch_q;
    row_d   = row_q;
    if (abort) begin
      // Abort wins over start/finish/ready; an acceptance in this cycle is dropped.
      phase_d = ST_IDLE;
      wait_d  = 1'b0;
      batch_d = CNT_ZERO;
      row_d   = CNT_ZERO;
    end else begin
      case (phase_q)
        ST_IDLE: begin
          if (start) begin
            phase_d = ST_BIAS;
            wait_d  = 1'b0;
            batch_d = CNT_ZERO;
            row_d   = CNT_ZERO;
          end else begin
            phase_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          phase_d = ST_IDLE;
          wait_d  = 1'b0;
          batch_d = CNT_ZERO;
          row_d   = CNT_ZERO;
        end
        default: begin
          if (!wait_q) begin
            // ISSUE: finish pulses here are ignored, not remembered.
            wait_d = cmd_valid_q && cmd_ready;
          end else if (task_finish) begin
            wait_d = 1'b0;
            case (phase_q)
              ST_BIAS:   phase_d = ST_LRELU;
              ST_LRELU:  phase_d = ST_WEIGHT;
              ST_WEIGHT: begin
                phase_d = ST_FEAT;
                batch_d = CNT_ZERO;
                row_d   = CNT_ZERO;
              end
              ST_FEAT:   phase_d = ST_CONV;
              ST_CONV: begin
                if (batch_q != BATCH_LAST) begin
                  phase_d = ST_FEAT;
                  batch_d = batch_q + CNT_ONE;
                end else begin
                  phase_d = ST_RX;
                  batch_d = CNT_ZERO;
                end
              end
              ST_RX: begin
                batch_d = CNT_ZERO;
                if (row_q != ROW_LAST) begin
                  phase_d = ST_FEAT;
                  row_d   = row_q + CNT_ONE;
                end else begin
                  phase_d = ST_DONE;
                  row_d   = CNT_ZERO;
                end
              end
              default: phase_d = ST_IDLE;
            endcase
          end else begin
            wait_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a flop aligned with the state.
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_type_d  = 3'd0;
    src_sel_d   = 3'd0;
    cmd_first_d = 1'b0;
    cmd_last_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cmd_batch_d = batch_d;
    cmd_row_d   = row_d;
    case (phase_d)
      ST_BIAS, ST_LRELU, ST_WEIGHT, ST_FEAT: begin
        cmd_valid_d = !wait_d;
        cmd_type_d  = phase_d;
        src_sel_d   = phase_d;
        busy_d      = 1'b1;
        cmd_first_d = (phase_d == ST_FEAT) && (row_d == CNT_ZERO);
        cmd_last_d  = (phase_d == ST_FEAT) && (row_d == ROW_LAST);
      end
      ST_CONV, ST_RX: begin
        cmd_valid_d = !wait_d;
        cmd_type_d  = phase_d;
        busy_d      = 1'b1;
        cmd_first_d = (row_d == CNT_ZERO);
        cmd_last_d  = (row_d == ROW_LAST);
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      phase_q     <= ST_IDLE;
      wait_q      <= 1'b0;
      batch_q     <= CNT_ZERO;
      row_q       <= CNT_ZERO;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 3'd0;
      cmd_batch_q <= CNT_ZERO;
      cmd_row_q   <= CNT_ZERO;
      cmd_first_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      src_sel_q   <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      wait_q      <= wait_d;
      batch_q     <= batch_d;
      row_q       <= row_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_batch_q <= cmd_batch_d;
      cmd_row_q   <= cmd_row_d;
      cmd_first_q <= cmd_first_d;
      cmd_last_q  <= cmd_last_d;
      src_sel_q   <= src_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_batch = cmd_batch_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_first = cmd_first_q;
  assign cmd_last  = cmd_last_q;
  assign src_sel   = src_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: expected commands are queued when a
// layer is started, monitors pop and compare on each accepted command.
module tb_conv_layer_scheduler;
  localparam int CW = 8;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  // DUT0 (defaults) signals
  logic s_rst_n, start, abort, cmd_ready, fin_auto, fin_inj, auto_fin;
  wire  task_finish = fin_auto | fin_inj;
  logic cmd_valid, cmd_first, cmd_last, busy, done;
  logic [2:0] cmd_type, src_sel;
  logic [CW-1:0] cmd_batch, cmd_row;

  // DUT1 (BATCH_NUM=1, ROW_GRP_NUM=1) signals
  logic start1, abort1, ready1, fin1;
  logic cmd_valid1, cmd_first1, cmd_last1, busy1, done1;
  logic [2:0] cmd_type1, src_sel1;
  logic [CW-1:0] cmd_batch1, cmd_row1;

  conv_layer_scheduler #(.BATCH_NUM(2), .ROW_GRP_NUM(13), .CNT_W(CW)) u_dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_batch(cmd_batch), .cmd_row(cmd_row), .cmd_first(cmd_first),
    .cmd_last(cmd_last), .task_finish(task_finish), .src_sel(src_sel),
    .busy(busy), .done(done));

  conv_layer_scheduler #(.BATCH_NUM(1), .ROW_GRP_NUM(1), .CNT_W(CW)) u_dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start1), .abort(abort1),
    .cmd_valid(cmd_valid1), .cmd_ready(ready1), .cmd_type(cmd_type1),
    .cmd_batch(cmd_batch1), .cmd_row(cmd_row1), .cmd_first(cmd_first1),
    .cmd_last(cmd_last1), .task_finish(fin1), .src_sel(src_sel1),
    .busy(busy1), .done(done1));

  wire [26:0] outs0 = {cmd_valid, cmd_type, cmd_batch, cmd_row, cmd_first, cmd_last,
                       src_sel, busy, done};
  wire [26:0] outs1 = {cmd_valid1, cmd_type1, cmd_batch1, cmd_row1, cmd_first1, cmd_last1,
                       src_sel1, busy1, done1};

  typedef struct packed {
    logic [2:0]    typ;
    logic [CW-1:0] batch;
    logic [CW-1:0] row;
    logic          first;
    logic          last;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int last_fin_cyc = -10;
  int done1_seen = 0;
  logic src_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int t, input int b, input int r, input int nr);
    cmd_t c;
    c.typ   = 3'(t);
    c.batch = CW'(b);
    c.row   = CW'(r);
    c.first = (t >= 4) && (r == 0);
    c.last  = (t >= 4) && (r == nr - 1);
    return c;
  endfunction

  // Queue the expected command stream of one layer, at most 'limit' commands.
  task automatic push_layer(input int nb, input int nr, input int limit);
    int n = 0;
    for (int t = 1; t <= 3; t++) begin
      if (n < limit) q0.push_back(mk(t, 0, 0, nr));
      n++;
    end
    for (int r = 0; r < nr; r++) begin
      for (int b = 0; b < nb; b++) begin
        if (n < limit) q0.push_back(mk(4, b, r, nr));
        n++;
        if (n < limit) q0.push_back(mk(5, b, r, nr));
        n++;
      end
      if (n < limit) q0.push_back(mk(6, 0, r, nr));
      n++;
    end
  endtask

  always @(posedge sclk) cyc <= cyc + 1;

  // Accelerator model for DUT0: finish pulse sampled 3 edges after each acceptance.
  initial begin
    logic acc;
    int pend;
    fin_auto = 1'b0;
    pend = 0;
    forever begin
      @(negedge sclk);
      acc = cmd_valid && cmd_ready;
      @(posedge sclk);
      #1;
      if (acc && auto_fin) pend = 3;
      else if (pend != 0) pend--;
      fin_auto = (pend == 1);
      if (fin_auto) last_fin_cyc = cyc;
    end
  end

  // Monitor DUT0: command scoreboard, done counting, src_sel against expected phase.
  initial begin
    logic [2:0] ph;
    cmd_t exp_c;
    ph = 3'd0;
    forever begin
      @(negedge sclk);
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        ph = 3'd0;
      end
      if (cmd_valid && q0.size() > 0) ph = q0[0].typ;
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got type %0d row %0d batch %0d expected none",
                   cmd_type, cmd_row, cmd_batch);
        end else begin
          exp_c = q0.pop_front();
          check("cmd0", {11'd0, cmd_type, cmd_batch, cmd_row, cmd_first, cmd_last}, {11'd0, exp_c});
        end
      end
      if (src_en) check("src_sel", {29'd0, src_sel}, {29'd0, (ph inside {3'd1, 3'd2, 3'd3, 3'd4}) ? ph : 3'd0});
    end
  end

  // Monitor DUT1
  initial begin
    cmd_t exp_c;
    forever begin
      @(negedge sclk);
      if (done1) done1_seen++;
      if (cmd_valid1 && ready1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd1: got type %0d expected none", cmd_type1);
        end else begin
          exp_c = q1.pop_front();
          check("cmd1", {11'd0, cmd_type1, cmd_batch1, cmd_row1, cmd_first1, cmd_last1}, {11'd0, exp_c});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < 2000) begin
      tick();
      n++;
    end
    check(name, done_seen - d0, 1);
  endtask

  initial begin
    logic reached;
    int d0;
    int n;
    s_rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_ready = 1'b1; fin_inj = 1'b0;
    auto_fin = 1'b1; start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; fin1 = 1'b0;
    repeat (3) @(posedge sclk);
    #2;
    check("reset_outs0", {5'd0, outs0}, 32'd0);
    check("reset_outs1", {5'd0, outs1}, 32'd0);
    s_rst_n = 1'b1;
    tick();

    // A: full layer, ready tied high, src_sel tracked every cycle
    acc_cnt = 0;
    src_en = 1'b1;
    push_layer(2, 13, 1000);
    pulse_start();
    check("A_start_latency", {cmd_valid, busy, cmd_type}, {1'b1, 1'b1, 3'd1});
    wait_done("A_done");
    check("A_idle_after", {busy, done, cmd_valid}, 3'b000);
    repeat (3) tick();
    check("A_cmd_count", acc_cnt, 68);
    check("A_done_latency", done_cyc, last_fin_cyc + 1);
    check("A_queue_empty", q0.size(), 0);
    src_en = 1'b0;

    // B: first FEAT stalled 5 cycles with a stray finish during the stall
    acc_cnt = 0;
    d0 = done_seen;
    push_layer(2, 13, 1000);
    pulse_start();
    n = 0;
    while (!(cmd_type == 3'd3 && !cmd_valid) && n < 50) begin tick(); n++; end
    reached = (cmd_type == 3'd3 && !cmd_valid);
    check("B_weight_wait", reached, 1);
    cmd_ready = 1'b0;
    n = 0;
    while (!cmd_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      check("B_stall_fields", {cmd_valid, cmd_type, cmd_batch, cmd_row, cmd_first, cmd_last, src_sel},
            {1'b1, 3'd4, 8'd0, 8'd0, 1'b1, 1'b0, 3'd4});
      fin_inj = (i == 1);
      tick();
    end
    fin_inj = 1'b0;
    check("B_still_pending", {cmd_valid, cmd_type}, {1'b1, 3'd4});
    cmd_ready = 1'b1;
    wait_done("B_done");
    repeat (2) tick();
    check("B_cmd_count", acc_cnt, 68);
    check("B_single_done", done_seen - d0, 1);
    check("B_queue_empty", q0.size(), 0);

    // C: abort in CONV row 5 batch 1, coincident with finish and start
    acc_cnt = 0;
    push_layer(2, 13, 32);
    pulse_start();
    n = 0;
    while (!(cmd_valid && cmd_type == 3'd5 && cmd_row == 8'd5 && cmd_batch == 8'd1) && n < 1000) begin
      tick(); n++;
    end
    reached = cmd_valid && cmd_type == 3'd5 && cmd_row == 8'd5 && cmd_batch == 8'd1;
    check("C_reach_conv5", reached, 1);
    n = 0;
    while (!fin_auto && n < 10) begin tick(); n++; end
    check("C_finish_seen", fin_auto, 1);
    abort = 1'b1;
    start = 1'b1;
    d0 = done_seen;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("C_abort_outs", {5'd0, outs0}, 32'd0);
    repeat (8) tick();
    check("C_no_done", done_seen - d0, 0);
    check("C_cmd_count", acc_cnt, 32);
    check("C_still_idle", {5'd0, outs0}, 32'd0);

    // D: stray finish in IDLE, restart from BIAS, start pulses while busy
    fin_inj = 1'b1;
    tick();
    fin_inj = 1'b0;
    tick();
    check("D_idle_fin_ignored", {5'd0, outs0}, 32'd0);
    acc_cnt = 0;
    d0 = done_seen;
    push_layer(2, 13, 1000);
    pulse_start();
    check("D_restart_bias", {cmd_valid, cmd_type, cmd_row, cmd_batch}, {1'b1, 3'd1, 8'd0, 8'd0});
    repeat (40) tick();
    pulse_start();
    repeat (57) tick();
    pulse_start();
    wait_done("D_done");
    repeat (3) tick();
    check("D_cmd_count", acc_cnt, 68);
    check("D_single_done", done_seen - d0, 1);
    check("D_queue_empty", q0.size(), 0);

    // E: single row-group, single batch instance
    q1.push_back(mk(1, 0, 0, 1));
    q1.push_back(mk(2, 0, 0, 1));
    q1.push_back(mk(3, 0, 0, 1));
    q1.push_back(mk(4, 0, 0, 1));
    q1.push_back(mk(5, 0, 0, 1));
    q1.push_back(mk(6, 0, 0, 1));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!cmd_valid1 && n < 20) begin tick(); n++; end
      tick();
      tick();
      fin1 = 1'b1;
      tick();
      fin1 = 1'b0;
    end
    check("E_done_latency", {done1, busy1}, 2'b10);
    tick();
    check("E_idle_after", {done1, busy1, cmd_valid1}, 3'b000);
    check("E_queue_empty", q1.size(), 0);
    check("E_single_done", done1_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
